// File: rtl/uart_joypad_ctrl_pkg.sv
// Shared types and constants for the controller host link: FSM encodings,
// the SPART register map and the NES button bit positions.
package uart_joypad_ctrl_pkg;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    GOT_SYNC = 2'd1,
    GOT_P1   = 2'd2,
    GOT_P2   = 2'd3
  } pkt_state_e;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } bus_state_e;

  localparam logic [1:0] ADDR_RXDATA = 2'b00;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Packet check byte: XOR of header and both button bytes.
  function automatic logic [7:0] pkt_checksum(input logic [7:0] sync,
                                              input logic [7:0] p1,
                                              input logic [7:0] p2);
    return sync ^ p1 ^ p2;
  endfunction

endpackage

// File: rtl/uart_joypad_ctrl_if.sv
// SPART register-bus bundle: baud enable, chip select/rw/address out,
// receive data and data-available back in.
interface uart_joypad_ctrl_if;
  logic       en;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] data;
  logic       rda;

  modport master (output en, iocs, iorw, ioaddr, input data, rda);
  modport slave  (input en, iocs, iorw, ioaddr, output data, rda);
endinterface

// File: rtl/uart_joypad_ctrl_joypad_shifter.sv
// NES-style serial shift-out for one player: parallel load while strobe is
// high, shift right filling ones on each CPU read while strobe is low.
module joypad_shifter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       strobe,
  input  logic       rd,
  input  logic [7:0] btn,
  output logic       ser_bit
);

  logic [7:0] shreg_r;

  // Shift register: strobe load has priority over read pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= 8'hFF;
    end else if (strobe) begin
      shreg_r <= btn;
    end else if (rd) begin
      shreg_r <= {1'b1, shreg_r[7:1]};
    end else begin
      shreg_r <= shreg_r;
    end
  end

  assign ser_bit = shreg_r[0];

endmodule

// File: rtl/uart_joypad_ctrl.sv
// Host-link sequencer: baud enable, SPART rx drain, 4-byte packet parser with
// link timeout, and two joypad shift-out channels.
module uart_joypad_ctrl
  import uart_joypad_ctrl_pkg::*;
#(
  parameter int         BAUD_DIV = 27,
  parameter int         TIMEOUT  = 500000,
  parameter logic [7:0] SYNC     = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_joypad_ctrl_if.master     spart,
  input  logic                   strobe,
  input  logic                   rd_p1,
  input  logic                   rd_p2,
  output logic                   p1_bit,
  output logic                   p2_bit,
  output logic                   link_ok,
  output logic                   pkt_err
);

  localparam int                BAUD_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = {{(BAUD_W-1){1'b0}}, 1'b1};
  localparam int                TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]   TO_ONE    = {{(TO_W-1){1'b0}}, 1'b1};

  logic [BAUD_W-1:0] baud_cnt_r;
  bus_state_e        bus_state_r, bus_next_s;
  pkt_state_e        pkt_state_r, pkt_next_s;
  logic [TO_W-1:0]   to_cnt_r;
  logic [7:0]        tmp1_r, tmp1_s, tmp2_r, tmp2_s;
  logic [7:0]        btn1_r, btn1_s, btn2_r, btn2_s;
  logic              link_r, link_s, err_r, err_s;
  logic              capture_s, timeout_s;
  logic [7:0]        byte_s;

  // Free-running 16x baud enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_r <= {BAUD_W{1'b0}};
    end else if (baud_cnt_r == BAUD_LAST) begin
      baud_cnt_r <= {BAUD_W{1'b0}};
    end else begin
      baud_cnt_r <= baud_cnt_r + BAUD_ONE;
    end
  end

  assign spart.en = (baud_cnt_r == BAUD_LAST);

  // Bus FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_state_r <= IDLE;
    end else begin
      bus_state_r <= bus_next_s;
    end
  end

  // One-cycle read per available byte; rda is re-sampled straight from IDLE.
  always_comb begin
    bus_next_s = bus_state_r;
    case (bus_state_r)
      IDLE: begin
        if (spart.rda) bus_next_s = READ;
        else           bus_next_s = IDLE;
      end
      READ:    bus_next_s = IDLE;
      default: bus_next_s = IDLE;
    endcase
  end

  assign spart.iocs   = (bus_state_r == READ);
  assign spart.iorw   = (bus_state_r == READ);
  assign spart.ioaddr = ADDR_RXDATA;
  assign capture_s    = (bus_state_r == READ);
  assign byte_s       = spart.data;

  // Inter-byte silence counter, saturating at TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (capture_s) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (to_cnt_r != TO_MAX) begin
      to_cnt_r <= to_cnt_r + TO_ONE;
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // A capture in the timeout cycle takes precedence over the link drop.
  assign timeout_s = (to_cnt_r == TO_MAX) && !capture_s;

  // Packet FSM and button/link datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_state_r <= HUNT;
      tmp1_r      <= 8'h00;
      tmp2_r      <= 8'h00;
      btn1_r      <= 8'h00;
      btn2_r      <= 8'h00;
      link_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      pkt_state_r <= pkt_next_s;
      tmp1_r      <= tmp1_s;
      tmp2_r      <= tmp2_s;
      btn1_r      <= btn1_s;
      btn2_r      <= btn2_s;
      link_r      <= link_s;
      err_r       <= err_s;
    end
  end

  // Packet parser next state; a failing check byte equal to SYNC restarts a packet.
  always_comb begin
    pkt_next_s = pkt_state_r;
    tmp1_s     = tmp1_r;
    tmp2_s     = tmp2_r;
    btn1_s     = btn1_r;
    btn2_s     = btn2_r;
    link_s     = link_r;
    err_s      = 1'b0;
    if (capture_s) begin
      case (pkt_state_r)
        HUNT: begin
          if (byte_s == SYNC) pkt_next_s = GOT_SYNC;
          else                pkt_next_s = HUNT;
        end
        GOT_SYNC: begin
          tmp1_s     = byte_s;
          pkt_next_s = GOT_P1;
        end
        GOT_P1: begin
          tmp2_s     = byte_s;
          pkt_next_s = GOT_P2;
        end
        GOT_P2: begin
          if (byte_s == pkt_checksum(SYNC, tmp1_r, tmp2_r)) begin
            btn1_s     = tmp1_r;
            btn2_s     = tmp2_r;
            link_s     = 1'b1;
            pkt_next_s = HUNT;
          end else begin
            err_s      = 1'b1;
            pkt_next_s = (byte_s == SYNC) ? GOT_SYNC : HUNT;
          end
        end
        default: pkt_next_s = HUNT;
      endcase
    end else if (timeout_s) begin
      pkt_next_s = HUNT;
      link_s     = 1'b0;
      btn1_s     = 8'h00;
      btn2_s     = 8'h00;
    end else begin
      pkt_next_s = pkt_state_r;
    end
  end

  assign link_ok = link_r;
  assign pkt_err = err_r;

  joypad_shifter u_shift_p1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .strobe  (strobe),
    .rd      (rd_p1),
    .btn     (btn1_r),
    .ser_bit (p1_bit)
  );

  joypad_shifter u_shift_p2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .strobe  (strobe),
    .rd      (rd_p2),
    .btn     (btn2_r),
    .ser_bit (p2_bit)
  );

endmodule
